// File: rtl/spi_master_param.sv
// Parametrised SPI master: configurable frame width, SCK divider, CPOL/CPHA and CS-high gap.
// Define SPI_MASTER_LSB_FIRST_EN to shift bit 0 first on both MOSI and MISO.
module spi_master_param #(
  parameter int unsigned FRAME_W = 16,
  parameter int unsigned CLK_DIV = 2,
  parameter bit          CPOL    = 1'b0,
  parameter bit          CPHA    = 1'b0,
  parameter int unsigned CS_IDLE = 2
) (
  input  logic               I_clk,
  input  logic               I_rst,
  input  logic               I_start,
  input  logic [FRAME_W-1:0] I_data_in,
  output logic               O_busy,
  output logic               O_done,
  output logic [FRAME_W-1:0] O_data_out,
  input  logic               I_spi_miso,
  output logic               O_spi_sck,
  output logic               O_spi_cs,
  output logic               O_spi_mosi
);

  localparam int unsigned DIV_W  = $clog2(CLK_DIV + 1);
  localparam int unsigned EDGE_W = $clog2(2 * FRAME_W + 1);
  localparam int unsigned GAP_W  = $clog2(CS_IDLE + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * FRAME_W);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(CS_IDLE - 1);

  typedef enum logic [2:0] {IDLE, LEAD, XFER, TRAIL, GAP} state_t;

  state_t             state;
  logic [DIV_W-1:0]   div_cnt;
  logic [EDGE_W-1:0]  edge_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [FRAME_W-1:0] tx;
  logic [FRAME_W-1:0] rx;

  logic               half_done_c;
  logic [EDGE_W-1:0]  edge_num_c;
  logic               load_bit_c;
  logic               tx_head_c;
  logic               tx_next_c;
  logic [FRAME_W-1:0] tx_shift_c;
  logic [FRAME_W-1:0] rx_shift_c;

  assign half_done_c = (div_cnt == DIV_LAST);
  assign edge_num_c  = edge_cnt + EDGE_W'(1);

  // Bit-order selection: head is the bit currently due on MOSI, next is the one after it.
`ifdef SPI_MASTER_LSB_FIRST_EN
  assign load_bit_c = I_data_in[0];
  assign tx_head_c  = tx[0];
  assign tx_next_c  = tx[1];
  assign tx_shift_c = tx >> 1;
  assign rx_shift_c = {I_spi_miso, rx[FRAME_W-1:1]};
`else
  assign load_bit_c = I_data_in[FRAME_W-1];
  assign tx_head_c  = tx[FRAME_W-1];
  assign tx_next_c  = tx[FRAME_W-2];
  assign tx_shift_c = tx << 1;
  assign rx_shift_c = {rx[FRAME_W-2:0], I_spi_miso};
`endif

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state      <= IDLE;
      div_cnt    <= '0;
      edge_cnt   <= '0;
      gap_cnt    <= '0;
      tx         <= '0;
      rx         <= '0;
      O_spi_cs   <= 1'b1;
      O_spi_sck  <= CPOL;
      O_spi_mosi <= 1'b0;
      O_busy     <= 1'b0;
      O_done     <= 1'b0;
      O_data_out <= '0;
    end else begin
      O_done <= 1'b0;
      case (state)
        IDLE: begin
          if (I_start) begin
            tx         <= I_data_in;
            rx         <= '0;
            div_cnt    <= '0;
            edge_cnt   <= '0;
            O_spi_cs   <= 1'b0;
            O_busy     <= 1'b1;
            O_spi_mosi <= CPHA ? 1'b0 : load_bit_c;
            state      <= LEAD;
          end
        end
        // LEAD's last half-period ends in edge 1, so it shares the edge logic with XFER.
        LEAD, XFER: begin
          if (half_done_c) begin
            div_cnt   <= '0;
            O_spi_sck <= ~O_spi_sck;
            edge_cnt  <= edge_num_c;
            if (edge_num_c[0] ^ CPHA) begin
              rx <= rx_shift_c;
            end else if (CPHA || (edge_num_c != EDGE_LAST)) begin
              O_spi_mosi <= CPHA ? tx_head_c : tx_next_c;
              tx         <= tx_shift_c;
            end
            state <= (edge_num_c == EDGE_LAST) ? TRAIL : XFER;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        TRAIL: begin
          if (half_done_c) begin
            div_cnt    <= '0;
            gap_cnt    <= '0;
            O_spi_sck  <= CPOL;
            O_spi_cs   <= 1'b1;
            O_spi_mosi <= 1'b0;
            O_done     <= 1'b1;
            O_data_out <= rx;
            state      <= GAP;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            O_busy <= 1'b0;
            state  <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
